// File: rtl/memory_controller_pkg.sv
// Shared definitions for the memory controller: access sizes, FSM encoding,
// the LSB request record and small address/size helpers.
package memory_controller_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd3;

    // Address bits [17:16] equal to this select the IO window.
    localparam logic [1:0] IO_SEL = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_READ  = 2'd1,
        LS_READ  = 2'd2,
        LS_WRITE = 2'd3
    } mc_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sign;
        logic        r_nw;
        logic [31:0] wdata;
    } lsb_req_t;

    // Size code 2 is undefined and behaves as a word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_io(input logic [31:0] addr);
        return addr[17:16] == IO_SEL;
    endfunction

endpackage

// File: rtl/memory_controller_load_extend.sv
// Combinational sign/zero extension of a byte or halfword load to 32 bits.
module load_extend
    import memory_controller_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] result
);

    always_comb begin
        case (size)
            SIZE_B:  result = {{24{sign & word[7]}}, word[7:0]};
            SIZE_H:  result = {{16{sign & word[15]}}, word[15:0]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/memory_controller.sv
// Byte-serial memory controller arbitrating between instruction fetch and
// load/store traffic onto an 8-bit RAM with one cycle of read latency.
module memory_controller
    import memory_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        lsb_flag,
    input  logic        lsb_r_nw,
    input  logic        load_sign,
    input  logic [1:0]  data_size_to_mc,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_write,
    output logic [31:0] data_read,
    output logic        data_rdy,
    output logic        lsb_enable,
    input  logic        if_flag,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_rdy,
    input  logic        mc_flush,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    mc_state_e   state_q, state_d;
    lsb_req_t    req_q, eff_req;
    logic        req_valid_q, eff_valid;
    logic        start_lsb, start_if;
    logic [31:0] addr_q, wdata_q, rbuf_q, assembled, ext_word;
    logic [1:0]  size_q;
    logic        sign_q, wr_q;
    logic [2:0]  cyc_q, next_idx, n_cur;
    logic [1:0]  cap_idx;
    logic        read_done, write_done;
    logic        frz_q;
    logic [7:0]  din_q, din_eff;

    assign n_cur      = byte_count(size_q);
    assign next_idx   = cyc_q + 3'd1;
    assign cap_idx    = cyc_q[1:0] - 2'd1;
    assign mem_wr     = wr_q && rdy && !(is_io(addr_q) && io_buffer_full);
    assign read_done  = (state_q == IF_READ || state_q == LS_READ) && cyc_q == n_cur;
    assign write_done = state_q == LS_WRITE && mem_wr && cyc_q == n_cur - 3'd1;
    assign lsb_enable = rst && !req_valid_q && state_q != LS_READ && state_q != LS_WRITE;

    // After a freeze the RAM already reflects the held address, so the byte
    // that belonged to the pre-freeze address is replayed from din_q.
    assign din_eff = frz_q ? din_q : mem_din;

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        eff_req   = req_q;
        eff_valid = req_valid_q;
        if (lsb_flag) begin
            eff_req.addr  = data_addr;
            eff_req.size  = data_size_to_mc;
            eff_req.sign  = load_sign;
            eff_req.r_nw  = lsb_r_nw;
            eff_req.wdata = data_write;
            eff_valid     = 1'b1;
        end
        start_lsb = 1'b0;
        start_if  = 1'b0;
        state_d   = state_q;
        case (state_q)
            IDLE: begin
                if (eff_valid && !(mc_flush && eff_req.r_nw)) begin
                    start_lsb = 1'b1;
                    state_d   = eff_req.r_nw ? LS_READ : LS_WRITE;
                end else if (!eff_valid && if_flag && !mc_flush) begin
                    start_if = 1'b1;
                    state_d  = IF_READ;
                end
            end
            IF_READ, LS_READ: if (mc_flush || read_done) state_d = IDLE;
            LS_WRITE:         if (write_done) state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    always_comb begin
        assembled = rbuf_q;
        if (cyc_q != 3'd0) assembled[{cap_idx, 3'b000} +: 8] = din_eff;
    end

    load_extend u_load_extend (
        .word   (assembled),
        .size   (size_q),
        .sign   (sign_q),
        .result (ext_word)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst)     state_q <= IDLE;
        else if (rdy) state_q <= state_d;
    end

    // Pending loads die on a flush; pending stores survive it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_valid_q <= 1'b0;
            req_q       <= '0;
        end else if (rdy) begin
            if (start_lsb) begin
                req_valid_q <= 1'b0;
            end else if (lsb_flag && !(mc_flush && lsb_r_nw)) begin
                req_valid_q <= 1'b1;
                req_q       <= eff_req;
            end else if (mc_flush && req_q.r_nw) begin
                req_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frz_q <= 1'b0;
            din_q <= '0;
        end else begin
            frz_q <= !rdy;
            if (!rdy && !frz_q) din_q <= mem_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rbuf_q    <= '0;
            size_q    <= SIZE_B;
            sign_q    <= 1'b0;
            cyc_q     <= '0;
            wr_q      <= 1'b0;
            mem_a     <= '0;
            mem_dout  <= '0;
            data_rdy  <= 1'b0;
            if_rdy    <= 1'b0;
            data_read <= '0;
            if_data   <= '0;
        end else if (rdy) begin
            data_rdy <= 1'b0;
            if_rdy   <= 1'b0;
            case (state_q)
                IDLE: begin
                    cyc_q <= '0;
                    if (start_lsb) begin
                        addr_q  <= eff_req.addr;
                        size_q  <= eff_req.size;
                        sign_q  <= eff_req.sign;
                        wdata_q <= eff_req.wdata;
                        mem_a   <= eff_req.addr;
                        if (!eff_req.r_nw) begin
                            mem_dout <= eff_req.wdata[7:0];
                            wr_q     <= 1'b1;
                        end
                    end else if (start_if) begin
                        addr_q <= if_addr;
                        size_q <= SIZE_W;
                        sign_q <= 1'b0;
                        mem_a  <= if_addr;
                    end
                end
                IF_READ, LS_READ: begin
                    if (!mc_flush) begin
                        rbuf_q <= assembled;
                        if (read_done) begin
                            if (state_q == IF_READ) begin
                                if_data <= assembled;
                                if_rdy  <= 1'b1;
                            end else begin
                                data_read <= ext_word;
                                data_rdy  <= 1'b1;
                            end
                        end else begin
                            cyc_q <= next_idx;
                            if (next_idx < n_cur) mem_a <= addr_q + 32'(next_idx);
                        end
                    end
                end
                LS_WRITE: begin
                    if (write_done) begin
                        wr_q     <= 1'b0;
                        data_rdy <= 1'b1;
                    end else if (mem_wr) begin
                        cyc_q    <= next_idx;
                        mem_a    <= addr_q + 32'(next_idx);
                        mem_dout <= wdata_q[{next_idx[1:0], 3'b000} +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// Directed self-checking bench for memory_controller with a 256-byte RAM model
// that returns data one cycle after the address.
module tb_memory_controller;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        lsb_flag, lsb_r_nw, load_sign;
    logic [1:0]  data_size_to_mc;
    logic [31:0] data_addr, data_write, data_read;
    logic        data_rdy, lsb_enable;
    logic        if_flag, if_rdy;
    logic [31:0] if_addr, if_data;
    logic        mc_flush;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    int tests = 0;
    int fails = 0;

    logic [7:0] ram [256];

    memory_controller dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .lsb_flag(lsb_flag), .lsb_r_nw(lsb_r_nw), .load_sign(load_sign),
        .data_size_to_mc(data_size_to_mc), .data_addr(data_addr),
        .data_write(data_write), .data_read(data_read), .data_rdy(data_rdy),
        .lsb_enable(lsb_enable), .if_flag(if_flag), .if_addr(if_addr),
        .if_data(if_data), .if_rdy(if_rdy), .mc_flush(mc_flush),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // RAM image is reloaded while reset is held low.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            ram[8'h00] <= 8'h78; ram[8'h01] <= 8'h56; ram[8'h02] <= 8'h34; ram[8'h03] <= 8'h12;
            ram[8'h10] <= 8'h80;
            ram[8'h20] <= 8'hFE; ram[8'h21] <= 8'hFF;
            ram[8'h40] <= 8'hEF; ram[8'h41] <= 8'hBE; ram[8'h42] <= 8'hAD; ram[8'h43] <= 8'hDE;
            ram[8'h60] <= 8'h44; ram[8'h61] <= 8'h33; ram[8'h62] <= 8'h22; ram[8'h63] <= 8'h11;
        end else if (mem_wr) begin
            ram[mem_a[7:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the start of the next cycle; lsb_flag is a one-cycle pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        lsb_flag = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                         input logic rnw, input logic [31:0] wd);
        lsb_flag        = 1'b1;
        data_addr       = a;
        data_size_to_mc = sz;
        load_sign       = sg;
        lsb_r_nw        = rnw;
        data_write      = wd;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; lsb_flag = 1'b0; lsb_r_nw = 1'b0; load_sign = 1'b0;
        data_size_to_mc = 2'd0; data_addr = '0; data_write = '0;
        if_flag = 1'b0; if_addr = '0; mc_flush = 1'b0; io_buffer_full = 1'b0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("rst_lsb_enable", lsb_enable, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_data_rdy", data_rdy, 0);
        check("rst_if_rdy", if_rdy, 0);
        check("rst_data_read", data_read, 0);
        check("rst_if_data", if_data, 0);
        tick(); rst = 1'b1;
        @(negedge clk);
        check("rel_lsb_enable", lsb_enable, 1);

        // LW 0x100: addresses in cycles 1-4, data_rdy in cycle 6
        tick(); issue(32'h100, 2'd3, 1'b0, 1'b1, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick(); @(negedge clk);
            check($sformatf("lw_mem_a_c%0d", k), mem_a, 32'h100 + 32'(k - 1));
            check($sformatf("lw_mem_wr_c%0d", k), mem_wr, 0);
        end
        check("lw_lsb_enable_busy", lsb_enable, 0);
        tick(); @(negedge clk); check("lw_rdy_c5", data_rdy, 0);
        tick(); @(negedge clk);
        check("lw_rdy_c6", data_rdy, 1);
        check("lw_data", data_read, 32'h12345678);
        check("lw_enable_c6", lsb_enable, 1);
        tick(); @(negedge clk);
        check("lw_rdy_c7", data_rdy, 0);
        check("lw_hold", data_read, 32'h12345678);

        // LB signed at 0x110: data_rdy in cycle 3
        tick(); issue(32'h110, 2'd0, 1'b1, 1'b1, 32'h0);
        tick(); tick(); @(negedge clk); check("lb_rdy_c2", data_rdy, 0);
        tick(); @(negedge clk);
        check("lb_rdy_c3", data_rdy, 1);
        check("lb_data", data_read, 32'hFFFFFF80);

        // LBU issued in the cycle right after the previous pulse
        tick(); issue(32'h110, 2'd0, 1'b0, 1'b1, 32'h0);
        tick(); @(negedge clk); check("lbu_mem_a", mem_a, 32'h110);
        tick(); tick(); @(negedge clk);
        check("lbu_rdy", data_rdy, 1);
        check("lbu_data", data_read, 32'h00000080);

        // LH signed at 0x120: data_rdy in cycle 4
        tick(); issue(32'h120, 2'd1, 1'b1, 1'b1, 32'h0);
        tick(); tick(); tick(); @(negedge clk); check("lh_rdy_c3", data_rdy, 0);
        tick(); @(negedge clk);
        check("lh_rdy_c4", data_rdy, 1);
        check("lh_data", data_read, 32'hFFFFFFFE);

        // IF and LSB together: LW first, then the fetch
        tick(); issue(32'h100, 2'd3, 1'b0, 1'b1, 32'h0); if_flag = 1'b1; if_addr = 32'h140;
        tick(); @(negedge clk); check("prio_mem_a_c1", mem_a, 32'h100);
        repeat (5) tick();
        @(negedge clk);
        check("prio_data_rdy_c6", data_rdy, 1);
        check("prio_if_rdy_c6", if_rdy, 0);
        tick(); @(negedge clk); check("prio_if_mem_a_c7", mem_a, 32'h140);
        repeat (4) tick();
        @(negedge clk); check("prio_if_rdy_c11", if_rdy, 0);
        tick(); if_flag = 1'b0; @(negedge clk);
        check("prio_if_rdy_c12", if_rdy, 1);
        check("prio_if_data", if_data, 32'hDEADBEEF);
        check("prio_no_overlap", data_rdy, 0);

        // SW to IO space with the buffer full in cycles 1-2
        tick(); issue(32'h30000, 2'd3, 1'b0, 1'b0, 32'hAABBCCDD);
        tick(); io_buffer_full = 1'b1; @(negedge clk);
        check("sw_io_wr_c1", mem_wr, 0);
        check("sw_io_a_c1", mem_a, 32'h30000);
        tick(); @(negedge clk); check("sw_io_wr_c2", mem_wr, 0);
        tick(); io_buffer_full = 1'b0; @(negedge clk);
        check("sw_io_wr_c3", mem_wr, 1);
        check("sw_io_dout_c3", mem_dout, 32'hDD);
        tick(); @(negedge clk); check("sw_io_dout_c4", mem_dout, 32'hCC);
        tick(); @(negedge clk); check("sw_io_a_c5", mem_a, 32'h30002);
        tick(); @(negedge clk);
        check("sw_io_dout_c6", mem_dout, 32'hAA);
        check("sw_io_rdy_c6", data_rdy, 0);
        tick(); @(negedge clk);
        check("sw_io_rdy_c7", data_rdy, 1);
        check("sw_io_wr_c7", mem_wr, 0);
        check("sw_io_ram0", ram[8'h00], 32'hDD);
        check("sw_io_ram3", ram[8'h03], 32'hAA);

        // Flush in cycle 3 of an IF read, then an LB right after
        tick(); if_flag = 1'b1; if_addr = 32'h140;
        tick(); if_flag = 1'b0;
        tick();
        tick(); mc_flush = 1'b1;
        tick(); mc_flush = 1'b0; issue(32'h110, 2'd0, 1'b0, 1'b1, 32'h0);
        @(negedge clk); check("fl_if_rdy_c4", if_rdy, 0);
        tick(); @(negedge clk);
        check("fl_idle_mem_a", mem_a, 32'h110);
        check("fl_if_rdy_c5", if_rdy, 0);
        tick(); @(negedge clk); check("fl_if_rdy_c6", if_rdy, 0);
        tick(); @(negedge clk);
        check("fl_if_rdy_c7", if_rdy, 0);
        check("fl_lb_rdy", data_rdy, 1);
        check("fl_lb_data", data_read, 32'h00000080);
        tick(); @(negedge clk); check("fl_if_rdy_c8", if_rdy, 0);

        // Flush in cycle 3 of a SW leaves it untouched
        tick(); issue(32'h30010, 2'd3, 1'b0, 1'b0, 32'h01020304);
        tick(); tick();
        tick(); mc_flush = 1'b1; @(negedge clk);
        check("fls_wr_c3", mem_wr, 1);
        check("fls_dout_c3", mem_dout, 32'h02);
        tick(); mc_flush = 1'b0; @(negedge clk);
        check("fls_wr_c4", mem_wr, 1);
        check("fls_dout_c4", mem_dout, 32'h01);
        tick(); @(negedge clk);
        check("fls_rdy_c5", data_rdy, 1);
        check("fls_ram", {ram[8'h13], ram[8'h12], ram[8'h11], ram[8'h10]}, 32'h01020304);

        // Freeze for 3 cycles mid-LW: data_rdy moves from cycle 6 to cycle 9
        tick(); issue(32'h160, 2'd3, 1'b0, 1'b1, 32'h0);
        tick(); tick();
        tick(); rdy = 1'b0;
        tick(); @(negedge clk);
        check("frz_wr_c4", mem_wr, 0);
        check("frz_mem_a_c4", mem_a, 32'h162);
        tick();
        tick(); rdy = 1'b1;
        tick(); tick(); @(negedge clk); check("frz_rdy_c8", data_rdy, 0);
        tick(); @(negedge clk);
        check("frz_rdy_c9", data_rdy, 1);
        check("frz_data", data_read, 32'h11223344);

        // Freeze during SW forces mem_wr low and retries the same byte
        tick(); issue(32'h30020, 2'd3, 1'b0, 1'b0, 32'h55667788);
        tick(); @(negedge clk); check("sfz_dout_c1", mem_dout, 32'h88);
        tick(); rdy = 1'b0; @(negedge clk); check("sfz_wr_c2", mem_wr, 0);
        tick(); rdy = 1'b1; @(negedge clk);
        check("sfz_wr_c3", mem_wr, 1);
        check("sfz_dout_c3", mem_dout, 32'h77);
        tick(); tick(); @(negedge clk); check("sfz_rdy_c5", data_rdy, 0);
        tick(); @(negedge clk); check("sfz_rdy_c6", data_rdy, 1);

        // Reset mid-LW discards it
        tick(); issue(32'h100, 2'd3, 1'b0, 1'b1, 32'h0);
        tick(); tick();
        tick(); rst = 1'b0; @(negedge clk); check("mrst_enable", lsb_enable, 0);
        tick(); rst = 1'b1; @(negedge clk);
        check("mrst_mem_a", mem_a, 0);
        check("mrst_data_read", data_read, 0);
        for (int k = 5; k <= 8; k++) begin
            tick(); @(negedge clk);
            check($sformatf("mrst_rdy_c%0d", k), data_rdy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
